// File: rtl/x1_prog_loader_pkg.sv
// Shared X1 definitions: loader FSM encoding, memory geometry and instruction fields.
// Optional feature macro: X1_LOADER_CKSUM_EN (adds the CKS state).
package x1_pkg;

  localparam int X1_MEM_DEPTH = 32;
  localparam int X1_INSTR_W   = 16;

  // X1 instruction word layout
  localparam int X1_SRC_MSB   = 15;
  localparam int X1_SRC_LSB   = 11;
  localparam int X1_DST_MSB   = 10;
  localparam int X1_DST_LSB   = 6;
  localparam int X1_OP_MSB    = 5;
  localparam int X1_OP_LSB    = 3;
  localparam int X1_SHAMT_MSB = 2;
  localparam int X1_SHAMT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
`ifdef X1_LOADER_CKSUM_EN
    ST_CKS  = 3'd4,
`endif
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } x1_state_e;

  function automatic logic x1_len_ok(input logic [7:0] len, input int depth);
    return (len != 8'd0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/x1_prog_loader_if.sv
// Loader bus: byte stream in, program-memory write port and session status out.
interface x1_prog_loader_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          start;
  logic [7:0]    inData;
  logic          inValid;
  logic          inReady;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          cpuRun;
  logic          busy;
  logic          err;
  logic [AW:0]   wordCount;

  modport master (
    output start, inData, inValid,
    input  inReady, memWe, memAddr, memWdata, cpuRun, busy, err, wordCount
  );

  modport slave (
    input  start, inData, inValid,
    output inReady, memWe, memAddr, memWdata, cpuRun, busy, err, wordCount
  );
endinterface

// File: rtl/x1_prog_loader_byte_pack.sv
// High-byte latch and instruction word assembly for the program loader.
module x1_byte_pack #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [7:0]    i_byte,
  output logic [DW-1:0] o_word
);

  logic [DW-9:0] r_hi;

  // high byte captured in HI, held until the low byte arrives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= {(DW-8){1'b0}};
    end else if (i_load) begin
      r_hi <= i_byte[DW-9:0];
    end else begin
      r_hi <= r_hi;
    end
  end

  assign o_word = {r_hi, i_byte};

endmodule

// File: rtl/x1_prog_loader.sv
// X1 program loader: length-prefixed byte image into program memory, then releases the CPU.
// Optional feature macro: X1_LOADER_CKSUM_EN (trailing XOR checksum byte).
module x1_prog_loader
  import x1_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic           cpuClk,
  input  logic           cpuRst,
  x1_prog_loader_if.slave bus
);

  localparam logic [AW:0] W_ONE = {{AW{1'b0}}, 1'b1};

  x1_state_e     r_state;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_err;
  logic          r_cpu_run;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [AW:0]   r_word_count;
  logic [AW:0]   r_len;
`ifdef X1_LOADER_CKSUM_EN
  logic [7:0]    r_cks;
`endif

  logic          w_accept;
  logic          w_hi_load;
  logic [AW:0]   w_count_inc;
  logic [DW-1:0] w_word;

  assign w_accept    = bus.inValid & r_in_ready;
  assign w_hi_load   = w_accept & (r_state == ST_HI);
  assign w_count_inc = r_word_count + W_ONE;

  x1_byte_pack #(.DW(DW)) u_pack (
    .i_clk  (cpuClk),
    .i_rst  (cpuRst),
    .i_load (w_hi_load),
    .i_byte (bus.inData),
    .o_word (w_word)
  );

  // session FSM; status outputs are set on the edge that enters each state
  always_ff @(posedge cpuClk) begin
    if (cpuRst) begin
      r_state      <= ST_IDLE;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {AW{1'b0}};
      r_mem_wdata  <= {DW{1'b0}};
      r_word_count <= {(AW+1){1'b0}};
      r_len        <= {(AW+1){1'b0}};
`ifdef X1_LOADER_CKSUM_EN
      r_cks        <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            r_state      <= ST_LEN;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_err        <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_word_count <= {(AW+1){1'b0}};
`ifdef X1_LOADER_CKSUM_EN
            r_cks        <= 8'd0;
`endif
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            r_len <= bus.inData[AW:0];
            if (x1_len_ok(bus.inData, DEPTH)) begin
              r_state <= ST_HI;
            end else begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (w_accept) begin
            r_state <= ST_LO;
`ifdef X1_LOADER_CKSUM_EN
            r_cks   <= r_cks ^ bus.inData;
`endif
          end
        end
        ST_LO: begin
          if (w_accept) begin
            r_mem_we     <= 1'b1;
            r_mem_addr   <= r_word_count[AW-1:0];
            r_mem_wdata  <= w_word;
            r_word_count <= w_count_inc;
`ifdef X1_LOADER_CKSUM_EN
            r_cks        <= r_cks ^ bus.inData;
`endif
            if (w_count_inc == r_len) begin
`ifdef X1_LOADER_CKSUM_EN
              r_state    <= ST_CKS;
`else
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_cpu_run  <= 1'b1;
`endif
            end else begin
              r_state <= ST_HI;
            end
          end
        end
`ifdef X1_LOADER_CKSUM_EN
        ST_CKS: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (bus.inData == r_cks) begin
              r_state   <= ST_DONE;
              r_cpu_run <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inReady   = r_in_ready;
  assign bus.memWe     = r_mem_we;
  assign bus.memAddr   = r_mem_addr;
  assign bus.memWdata  = r_mem_wdata;
  assign bus.cpuRun    = r_cpu_run;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.wordCount = r_word_count;

endmodule
